seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 21 ++
 rtl/seq_divider.sv | 109 ++++++++++
 tb/tb_seq_divider.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared widths, step count and state encoding for the sequential divider
package div_pkg;

  localparam int WIDTH      = 32;
  localparam int ITERATIONS = 32;
  localparam int CNT_W      = $clog2(ITERATIONS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract step
module div_step
  import div_pkg::*;
(
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  assign trial = {rem_in[WIDTH-1:0], dividend_bit};
  assign diff  = trial - {1'b0, divisor};
  // A set top bit means the shifted value has already reached 2^WIDTH, above any divisor.
  assign q_bit   = rem_in[WIDTH] | (trial >= {1'b0, divisor});
  assign rem_out = q_bit ? diff : trial;

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - 32-step signed restoring divider with zero-divisor handling
module seq_divider
  import div_pkg::*;
(
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);

  div_state_e       state;
  div_state_e       state_next;
  logic [WIDTH-1:0] divisor_abs;
  logic [WIDTH-1:0] quo_shift;
  logic [WIDTH:0]   rem;
  logic [CNT_W-1:0] count;
  logic             neg_dividend;
  logic             neg_divisor;
  logic             zero_div;
  logic [WIDTH:0]   rem_step;
  logic             q_bit;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] rem_final;

  div_step u_step (
    .rem_in      (rem),
    .dividend_bit(quo_shift[WIDTH-1]),
    .divisor     (divisor_abs),
    .rem_out     (rem_step),
    .q_bit       (q_bit)
  );

  // quo_shift starts as |dividend| and is shifted out while quotient bits shift in;
  // with a zero divisor it is never shifted, so it still holds |dividend| in FIX.
  assign quo_final = (neg_dividend ^ neg_divisor) ? -quo_shift : quo_shift;
  assign rem_mag   = zero_div ? quo_shift : rem[WIDTH-1:0];
  assign rem_final = neg_dividend ? -rem_mag : rem_mag;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (Start) state_next = (Divisor == '0) ? FIX : RUN;
      RUN:  if (count == '0) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Quotient     <= '0;
      Remainder    <= '0;
      DivByZero    <= 1'b0;
      divisor_abs  <= '0;
      quo_shift    <= '0;
      rem          <= '0;
      count        <= '0;
      neg_dividend <= 1'b0;
      neg_divisor  <= 1'b0;
      zero_div     <= 1'b0;
    end else begin
      Busy <= (state_next != IDLE);
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            divisor_abs  <= abs_val(Divisor);
            quo_shift    <= abs_val(Dividend);
            rem          <= '0;
            neg_dividend <= Dividend[WIDTH-1];
            neg_divisor  <= Divisor[WIDTH-1];
            zero_div     <= (Divisor == '0);
            count        <= CNT_W'(ITERATIONS - 1);
          end
        end
        RUN: begin
          rem       <= rem_step;
          quo_shift <= {quo_shift[WIDTH-2:0], q_bit};
          count     <= count - CNT_W'(1);
        end
        FIX: begin
          Quotient  <= zero_div ? '1 : quo_final;
          Remainder <= rem_final;
          DivByZero <= zero_div;
          Done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - randomized self-checking bench for seq_divider
module tb_seq_divider;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [31:0] Dividend;
  logic [31:0] Divisor;
  logic        Busy;
  logic        Done;
  logic [31:0] Quotient;
  logic [31:0] Remainder;
  logic        DivByZero;

  int checks = 0;
  int errors = 0;

  seq_divider dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Start    (Start),
    .Dividend (Dividend),
    .Divisor  (Divisor),
    .Busy     (Busy),
    .Done     (Done),
    .Quotient (Quotient),
    .Remainder(Remainder),
    .DivByZero(DivByZero)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Architectural result of a signed divide, straight from the integer rules.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dz);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'h0) begin
      q = 32'hFFFFFFFF; r = a; dz = 1'b1;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      q = 32'h80000000; r = 32'h0; dz = 1'b0;
    end else begin
      q = sa / sb; r = sa % sb; dz = 1'b0;
    end
  endfunction

  // Present a request, let the accepting edge pass, then scramble the operand bus.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Dividend = a; Divisor = b;
    @(posedge Clock);
    #1;
    Start = 1'b0; Dividend = $urandom; Divisor = $urandom;
  endtask

  // lat = index of the first negedge (0 = just after accept edge) with Done high; -1 on timeout.
  task automatic wait_done(output int lat, output logic busy_ok);
    lat = -1;
    busy_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      if (Done) begin
        lat = i;
        break;
      end
      if (!Busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; Start = 1'b0; Dividend = '0; Divisor = '0;
    repeat (2) @(negedge Clock);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", Done); end
    checks++; if ({Quotient, Remainder} !== 64'h0) begin errors++; $display("FAIL reset_outputs got %h %h want 0 0", Quotient, Remainder); end
    checks++; if (DivByZero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", DivByZero); end
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_basic;
    int lat;
    logic busy_ok;
    logic [31:0] q0, r0;
    launch(32'h12, 32'h14);
    wait_done(lat, busy_ok);
    checks++; if (lat !== 33) begin errors++; $display("FAIL basic_latency got %0d want 33", lat); end
    checks++; if (busy_ok !== 1'b1) begin errors++; $display("FAIL basic_busy_during got 0 want 1"); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", Busy); end
    checks++; if (Quotient !== 32'h0 || Remainder !== 32'h12) begin errors++; $display("FAIL basic_result got %h %h want 0 12", Quotient, Remainder); end
    q0 = Quotient; r0 = Remainder;
    repeat (3) @(negedge Clock);
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", Done); end
    checks++; if (Quotient !== q0 || Remainder !== r0) begin errors++; $display("FAIL basic_hold got %h %h want %h %h", Quotient, Remainder, q0, r0); end
  endtask

  task automatic test_signs;
    int lat;
    logic busy_ok;
    launch(32'hFFFFFFF9, 32'h2);
    wait_done(lat, busy_ok);
    checks++; if (Quotient !== 32'hFFFFFFFD || Remainder !== 32'hFFFFFFFF) begin errors++; $display("FAIL signs_neg_dividend got %h %h want fffffffd ffffffff", Quotient, Remainder); end
    launch(32'h7, 32'hFFFFFFFE);
    wait_done(lat, busy_ok);
    checks++; if (Quotient !== 32'hFFFFFFFD || Remainder !== 32'h1) begin errors++; $display("FAIL signs_neg_divisor got %h %h want fffffffd 1", Quotient, Remainder); end
  endtask

  task automatic test_div_zero;
    int lat;
    logic busy_ok;
    @(negedge Clock);
    launch(32'h55, 32'h0);
    wait_done(lat, busy_ok);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency got %0d want 1", lat); end
    checks++; if (Quotient !== 32'hFFFFFFFF || Remainder !== 32'h55 || DivByZero !== 1'b1) begin errors++; $display("FAIL zero_result got %h %h %b want ffffffff 55 1", Quotient, Remainder, DivByZero); end
  endtask

  task automatic test_overflow;
    int lat;
    logic busy_ok;
    launch(32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, busy_ok);
    checks++; if (Quotient !== 32'h80000000 || Remainder !== 32'h0 || DivByZero !== 1'b0) begin errors++; $display("FAIL overflow_result got %h %h %b want 80000000 0 0", Quotient, Remainder, DivByZero); end
  endtask

  task automatic test_random;
    int lat;
    logic busy_ok;
    logic [31:0] a, b, eq, er;
    logic edz;
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        3: begin a = 32'h80000000; b = $urandom; end
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      model(a, b, eq, er, edz);
      @(negedge Clock);
      launch(a, b);
      wait_done(lat, busy_ok);
      checks++;
      if (Quotient !== eq || Remainder !== er || DivByZero !== edz || lat !== ((b == 32'h0) ? 1 : 33)) begin
        errors++;
        $display("FAIL random %h/%h got q=%h r=%h dz=%b lat=%0d want q=%h r=%h dz=%b", a, b, Quotient, Remainder, DivByZero, lat, eq, er, edz);
      end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic busy_ok;
    @(negedge Clock);
    launch(32'h12, 32'h14);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge Clock);
      if (i == 9) begin Start = 1'b1; Dividend = 32'd100; Divisor = 32'd7; end
      if (i == 10) Start = 1'b0;
      if (Done) begin lat = i; break; end
    end
    checks++; if (lat !== 33) begin errors++; $display("FAIL ignore_latency got %0d want 33", lat); end
    checks++; if (Quotient !== 32'h0 || Remainder !== 32'h12) begin errors++; $display("FAIL ignore_result got %h %h want 0 12", Quotient, Remainder); end
    launch(32'd100, 32'd7);
    wait_done(lat, busy_ok);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", lat); end
    checks++; if (Quotient !== 32'd14 || Remainder !== 32'd2) begin errors++; $display("FAIL b2b_result got %h %h want e 2", Quotient, Remainder); end
  endtask

  task automatic test_reset_mid;
    int lat;
    logic busy_ok;
    logic seen_done;
    @(negedge Clock);
    launch(32'd100, 32'd7);
    repeat (15) @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    checks++; if (Busy !== 1'b0 || Done !== 1'b0) begin errors++; $display("FAIL midreset_ctrl got busy=%b done=%b want 0 0", Busy, Done); end
    checks++; if ({Quotient, Remainder} !== 64'h0 || DivByZero !== 1'b0) begin errors++; $display("FAIL midreset_outputs got %h %h %b want 0 0 0", Quotient, Remainder, DivByZero); end
    @(negedge Clock);
    Reset = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge Clock);
      if (Done || Busy) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL midreset_no_done got 1 want 0"); end
    launch(32'd100, 32'd7);
    wait_done(lat, busy_ok);
    checks++; if (Quotient !== 32'd14 || Remainder !== 32'd2 || lat !== 33) begin errors++; $display("FAIL midreset_fresh got %h %h lat=%0d want e 2 lat=33", Quotient, Remainder, lat); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signs;
    test_div_zero;
    test_overflow;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
